// File: rtl/cos_pkg.sv
// Shared types and widths for the cos core sequencer.
package cos_pkg;

  localparam int X_W         = 16;
  localparam int Y_W         = 16;
  localparam int TERMS_W     = 8;
  localparam int TIMEOUT_DEF = 1023;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    HOLD   = 2'd3
  } state_e;

endpackage

// File: rtl/cos_sample_fifo.sv
// Sample buffer: register array with wrap-around pointers and an occupancy count.
// A push while full is dropped unless a pop happens in the same cycle.
module cos_sample_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/cos_sequencer.sv
// Feeds buffered angle samples to the cos core one at a time and holds each result
// for the consumer. Optional watchdog on core_done: COS_SEQ_TIMEOUT_EN.
//   state  | meaning
//   IDLE   | waiting for a buffered sample
//   LAUNCH | core_start high, operands stable
//   WAIT   | waiting for core_done
//   HOLD   | out_valid high until out_ready
module cos_sequencer
  import cos_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [X_W-1:0]     in_x,
  output logic               in_ready,
  input  logic [TERMS_W-1:0] cfg_terms,
  output logic               core_start,
  output logic [X_W-1:0]     core_x,
  output logic [TERMS_W-1:0] core_y,
  input  logic               core_done,
  input  logic [Y_W-1:0]     core_total,
  output logic               out_valid,
  output logic [Y_W-1:0]     out_data,
  input  logic               out_ready,
  output logic               err
);

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT < 1)
  begin : g_param_check
    $error("cos_sequencer: FIFO_DEPTH must be a power of two in 2..16 and TIMEOUT >= 1");
  end

  state_e             state_q;
  logic               core_start_q;
  logic [X_W-1:0]     core_x_q;
  logic [TERMS_W-1:0] core_y_q;
  logic               out_valid_q;
  logic [Y_W-1:0]     out_data_q;

  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic [X_W-1:0]     fifo_rdata;

  assign in_ready = !fifo_full;
  assign fifo_pop = (state_q == IDLE) && !fifo_empty;

  cos_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (X_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_valid && in_ready),
    .pop_i   (fifo_pop),
    .wdata_i (in_x),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef COS_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q;
  logic            err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      core_start_q <= 1'b0;
      core_x_q     <= '0;
      core_y_q     <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
`ifdef COS_SEQ_TIMEOUT_EN
      wd_q         <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      core_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            core_x_q     <= fifo_rdata;
            core_y_q     <= cfg_terms;
            core_start_q <= 1'b1;
            state_q      <= LAUNCH;
          end
        end
        LAUNCH: begin
          state_q <= WAIT;
`ifdef COS_SEQ_TIMEOUT_EN
          wd_q    <= WD_W'(TIMEOUT - 1);
`endif
        end
        WAIT: begin
          if (core_done) begin
            out_data_q  <= core_total;
            out_valid_q <= 1'b1;
            state_q     <= HOLD;
          end
`ifdef COS_SEQ_TIMEOUT_EN
          // Watchdog expiry drops the sample; the result slot stays empty.
          else if (wd_q == '0) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            wd_q <= wd_q - 1'b1;
          end
`endif
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign core_start = core_start_q;
  assign core_x     = core_x_q;
  assign core_y     = core_y_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;

endmodule
